// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
// Memory-mapped 8N1 UART transmitter that sits on the CPU data bus.
// Stores to BASE+0 push bytes into a transmit FIFO. Loads from BASE+1
// return status. A serialiser drains the FIFO onto o_tx at a fixed
// baud divisor.
//
// Ports
//   i_clk    system clock
//   i_rst    synchronous reset, active-high
//   i_addr   CPU bus address
//   i_wdata  CPU write data
//   i_we     CPU write strobe, one cycle per store
//   o_rdata  registered read data toward the CPU
//   o_sel    combinational: high when i_addr is BASE_ADDR or BASE_ADDR+1
//   o_tx     serial line, idle high
//
// Register map
//   BASE+0  W: push byte          R: 8'h00
//   BASE+1  W: bit3=1 clears overflow
//           R: {4'b0, overflow, busy, empty, full}
//
// Serialiser states
//   state   | meaning
//   S_IDLE  | line high, pops the FIFO head when one is available
//   S_START | start bit (low) for CLKS_PER_BIT cycles
//   S_DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
//   S_STOP  | stop bit (high) for CLKS_PER_BIT cycles
module uart_tx_mmio #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  input  logic        i_we,
  output logic [7:0]  o_rdata,
  output logic        o_sel,
  output logic        o_tx
);

  localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [15:0] BAUD_TC   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Serialiser state
  state_t      r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_tx;

  // FIFO state
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic [7:0]  r_rdata;

  // Decode and handshake wires
  logic        w_hit_data;
  logic        w_hit_stat;
  logic        w_full;
  logic        w_empty;
  logic        w_busy;
  logic        w_pop;
  logic        w_push_req;
  logic        w_push_ok;
  logic        w_ovf_set;
  logic        w_ovf_clr;
  logic        w_baud_tc;
  logic [7:0]  w_head;
  logic [7:0]  w_status;

  assign w_hit_data = (i_addr == BASE_ADDR);
  assign w_hit_stat = (i_addr == STAT_ADDR);
  assign o_sel      = w_hit_data | w_hit_stat;

  assign w_full     = (r_count == DEPTH_CNT);
  assign w_empty    = (r_count == '0);
  assign w_busy     = (r_state != S_IDLE);
  assign w_baud_tc  = (r_baud == BAUD_TC);
  assign w_head     = r_mem[r_rd_ptr];

  // The serialiser takes the head on any IDLE edge with data waiting.
  assign w_pop      = (r_state == S_IDLE) && !w_empty;

  // A push into a full FIFO still fits when the head leaves on the same
  // edge, so only a push with no slot freeing up is dropped.
  assign w_push_req = i_we && w_hit_data;
  assign w_push_ok  = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = i_we && w_hit_stat && i_wdata[3];

  assign w_status   = {4'b0000, r_overflow, w_busy, w_empty, w_full};

  // FIFO storage has no reset; only the pointers and count define content.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (w_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Read data is captured from the pre-edge state, so a status read on the
  // same edge as a push reports the FIFO before that push.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= 8'h00;
    end else if (w_hit_stat) begin
      r_rdata <= w_status;
    end else begin
      r_rdata <= 8'h00;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_baud    <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= 16'd0;
          if (w_pop) begin
            r_shift <= w_head;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_baud_tc) begin
            // Present bit 0 now and pre-shift so r_shift[0] is always
            // the next bit to send.
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end

        S_DATA: begin
          if (w_baud_tc) begin
            r_baud <= 16'd0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end

        S_STOP: begin
          r_tx <= 1'b1;
          if (w_baud_tc) begin
            r_baud  <= 16'd0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_baud  <= 16'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_rdata = r_rdata;
  assign o_tx    = r_tx;

endmodule
